// File: rtl/approx_mult_pipe.sv
// Pipelined 2Hx2H unsigned multiplier assembled from four HxH quadrant products.
// Each quadrant can be truncated at runtime, quadrants combine by add or OR, and mismatches are counted.
module approx_mult_pipe #(
  parameter int H     = 4,
  parameter int TRUNC = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_qmode,
  input  logic               cfg_comb,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*H-1:0]     in_a,
  input  logic [2*H-1:0]     in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*H-1:0]     out_r,
  output logic               out_mis,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam int W  = 2 * H;
  localparam int RW = 4 * H;
  localparam logic [W-1:0] TRUNC_MASK = {W{1'b1}} << TRUNC;

  logic [3:0]          cfg_qmode_q;
  logic                cfg_comb_q;

  logic                s1_valid_q;
  logic [W-1:0]        s1_a_q, s1_b_q;
  logic [3:0]          s1_qmode_q;
  logic                s1_comb_q;

  logic                s2_valid_q;
  logic [3:0][W-1:0]   s2_p_q;
  logic [RW-1:0]       s2_exact_q;
  logic                s2_comb_q;

  logic                s3_valid_q;
  logic [RW-1:0]       s3_r_q, s3_exact_q;

  logic                out_valid_q;
  logic [RW-1:0]       out_r_q;
  logic                out_mis_q;
  logic [CNT_W-1:0]    err_cnt_q;

  logic                stall;
  logic                out_hs;
  logic [3:0][W-1:0]   quad_raw, quad_d;
  logic [RW-1:0]       exact_d;
  logic [RW-1:0]       pll, plh, phl, phh;
  logic [RW-1:0]       r_d;
  logic                mis_d;

  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = !stall;
  assign out_hs    = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_mis   = out_mis_q;
  assign err_cnt   = err_cnt_q;

  // Quadrant index follows the qmode bit order: LL, LH (A_lo*B_hi), HL (A_hi*B_lo), HH.
  always_comb begin
    quad_raw[0] = W'(s1_a_q[H-1:0]) * W'(s1_b_q[H-1:0]);
    quad_raw[1] = W'(s1_a_q[H-1:0]) * W'(s1_b_q[W-1:H]);
    quad_raw[2] = W'(s1_a_q[W-1:H]) * W'(s1_b_q[H-1:0]);
    quad_raw[3] = W'(s1_a_q[W-1:H]) * W'(s1_b_q[W-1:H]);
    for (int q = 0; q < 4; q++) begin
      quad_d[q] = s1_qmode_q[q] ? (quad_raw[q] & TRUNC_MASK) : quad_raw[q];
    end
    exact_d = RW'(s1_a_q) * RW'(s1_b_q);
  end

  always_comb begin
    pll   = RW'(s2_p_q[0]);
    plh   = RW'(s2_p_q[1]) << H;
    phl   = RW'(s2_p_q[2]) << H;
    phh   = RW'(s2_p_q[3]) << W;
    r_d   = s2_comb_q ? (phh | phl | plh | pll) : (phh + phl + plh + pll);
    mis_d = (s3_r_q != s3_exact_q);
  end

  // NOTE: every register is reset here, datapath included, so out_r reads 0 after reset
  // and no stale operand can surface once the valids are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_qmode_q <= '0;
      cfg_comb_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_qmode_q  <= '0;
      s1_comb_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_p_q      <= '0;
      s2_exact_q  <= '0;
      s2_comb_q   <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_r_q      <= '0;
      s3_exact_q  <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_mis_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (cfg_we) begin
        cfg_qmode_q <= cfg_qmode;
        cfg_comb_q  <= cfg_comb;
      end

      // The whole pipe moves as one; an accepted operand captures the pre-update config.
      if (!stall) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_a_q     <= in_a;
          s1_b_q     <= in_b;
          s1_qmode_q <= cfg_qmode_q;
          s1_comb_q  <= cfg_comb_q;
        end
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_p_q     <= quad_d;
          s2_exact_q <= exact_d;
          s2_comb_q  <= s1_comb_q;
        end
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          s3_r_q     <= r_d;
          s3_exact_q <= s2_exact_q;
        end
        out_valid_q <= s3_valid_q;
        if (s3_valid_q) begin
          out_r_q   <= s3_r_q;
          out_mis_q <= mis_d;
        end
      end

      if (err_clr) begin
        err_cnt_q <= '0;
      end else if (out_hs && out_mis_q && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed bench for approx_mult_pipe at H=4, TRUNC=2, CNT_W=16.
// Expected values are hand-derived quadrant sums or plain a*b for exact configurations.
module tb_approx_mult_pipe;

  localparam int H     = 4;
  localparam int TRUNC = 2;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [3:0]        cfg_qmode;
  logic              cfg_comb;
  logic              in_valid;
  logic              in_ready;
  logic [2*H-1:0]    in_a, in_b;
  logic              out_valid;
  logic              out_ready;
  logic [4*H-1:0]    out_r;
  logic              out_mis;
  logic              err_clr;
  logic [CNT_W-1:0]  err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  approx_mult_pipe #(.H(H), .TRUNC(TRUNC), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_qmode (cfg_qmode),
    .cfg_comb  (cfg_comb),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_mis   (out_mis),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [3:0] q, input logic c);
    cfg_we    = 1'b1;
    cfg_qmode = q;
    cfg_comb  = c;
    step();
    cfg_we    = 1'b0;
  endtask

  // Issues one operand pair and stops in the first cycle where out_valid is high.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp_r, input logic exp_mis, input string tag);
    int cycles;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    cycles   = 0;
    do begin
      step();
      cycles++;
    end while (!out_valid && cycles < 10);
    check({tag, "_latency"}, cycles, 3);
    check({tag, "_out_r"}, out_r, exp_r);
    check({tag, "_out_mis"}, out_mis, exp_mis);
  endtask

  logic [7:0]  va [8] = '{8'hFF, 8'h12, 8'h80, 8'h7F, 8'h01, 8'h00, 8'hA5, 8'h3C};
  logic [7:0]  vb [8] = '{8'hFF, 8'h34, 8'h80, 8'h81, 8'hFF, 8'h99, 8'h5A, 8'hC3};
  logic [15:0] vexp [8];

  initial begin
    int sent, recv, stale, n_sat;
    logic acc;

    rst = 1'b1; cfg_we = 1'b0; cfg_qmode = '0; cfg_comb = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; err_clr = 1'b0;
    for (int i = 0; i < 8; i++) vexp[i] = 16'(va[i]) * 16'(vb[i]);
    repeat (2) step();
    rst = 1'b0;

    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_r",     out_r,     16'h0000);
    check("rst_out_mis",   out_mis,   1'b0);
    check("rst_err_cnt",   err_cnt,   16'h0000);
    check("rst_in_ready",  in_ready,  1'b1);

    // Reset config is an exact multiplier.
    do_op(8'hFF, 8'hFF, 16'hFE01, 1'b0, "exact_ff");
    step();
    check("exact_ff_cnt", err_cnt, 16'd0);

    set_cfg(4'hF, 1'b1);
    do_op(8'hFF, 8'hFF, 16'hEEE0, 1'b1, "or_approx_ff");
    check("or_approx_cnt_before", err_cnt, 16'd0);
    step();
    check("or_approx_cnt_after", err_cnt, 16'd1);

    set_cfg(4'h0, 1'b1);
    do_op(8'h12, 8'h34, 16'h0368, 1'b1, "or_exactq");
    step();
    check("or_exactq_cnt", err_cnt, 16'd2);

    // LH = 2*3 = 6 truncates to 4; HL = 1*4 = 4 is unaffected.
    set_cfg(4'h2, 1'b0);
    do_op(8'h12, 8'h34, 16'h0388, 1'b1, "add_lh");
    step();
    set_cfg(4'h4, 1'b0);
    do_op(8'h12, 8'h34, 16'h03A8, 1'b0, "add_hl");
    step();
    check("add_q_cnt", err_cnt, 16'd3);

    // Back-to-back stream with a 4-cycle downstream stall.
    set_cfg(4'h0, 1'b0);
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 8);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_a = va[sent];
        in_b = vb[sent];
      end
      #1;
      if (cyc >= 5 && cyc <= 8) check("stall_in_ready", in_ready, 1'b0);
      if (out_valid) begin
        if (recv < 8) check($sformatf("stream_out_r_%0d", recv), out_r, vexp[recv]);
        else          check("stream_extra_out", out_valid, 1'b0);
        if (out_ready) recv++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_sent", sent, 8);
    check("stream_recv", recv, 8);

    // Config changes while operands are in flight.
    set_cfg(4'hF, 1'b1);
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
    cfg_we = 1'b1; cfg_qmode = 4'h0; cfg_comb = 1'b0;
    step();
    cfg_qmode = 4'h1;
    step();
    cfg_we = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    check("cfgfly_op1_valid", out_valid, 1'b1);
    check("cfgfly_op1_r", out_r, 16'hEEE0);
    check("cfgfly_op1_mis", out_mis, 1'b1);
    step();
    check("cfgfly_op2_r", out_r, 16'hFE01);
    check("cfgfly_op2_mis", out_mis, 1'b0);
    step();
    check("cfgfly_op3_r", out_r, 16'hFE00);
    check("cfgfly_op3_mis", out_mis, 1'b1);
    step();
    check("cfgfly_drained", out_valid, 1'b0);
    check("cfgfly_cnt", err_cnt, 16'd5);

    // Drive the counter to saturation with a continuous mismatching stream.
    set_cfg(4'hF, 1'b1);
    n_sat = 65535 - 5;
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
    repeat (n_sat) step();
    in_valid = 1'b0;
    repeat (5) step();
    check("sat_reach", err_cnt, 16'hFFFF);
    do_op(8'hFF, 8'hFF, 16'hEEE0, 1'b1, "sat_op");
    step();
    check("sat_hold", err_cnt, 16'hFFFF);
    do_op(8'hFF, 8'hFF, 16'hEEE0, 1'b1, "clr_op");
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_priority", err_cnt, 16'h0000);

    // Fill the pipe under stall, then reset it.
    do_op(8'hFF, 8'hFF, 16'hEEE0, 1'b1, "pre_rst_op");
    step();
    check("pre_rst_cnt", err_cnt, 16'd1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34;
    repeat (4) step();
    check("full_out_valid", out_valid, 1'b1);
    check("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_err_cnt", err_cnt, 16'h0000);
    check("midrst_out_r", out_r, 16'h0000);
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      step();
      if (out_valid) stale++;
    end
    check("midrst_no_stale", stale, 0);
    do_op(8'hFF, 8'hFF, 16'hFE01, 1'b0, "post_rst_exact");
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
